// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-side bundle; slave is the arbiter, master the environment.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int IDW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr;
    logic [DATA_WIDTH-1:0]         fifo_w_data;
    logic                          grant_valid;
    logic [IDW-1:0]                grant_id;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_w_data, grant_valid, grant_id
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_w_data, grant_valid, grant_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority select: first requester above last_grant, wrapping.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_grant_i,
    output logic [IDW-1:0]     grant_o,
    output logic               any_o
);

    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == (int'(last_grant_i) + k) % NUM_REQ && req_i[j]) begin
                    grant_o = IDW'(j);
                    any_o   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset_n,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int IDW  = idx_w(NUM_REQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [CNTW-1:0]  beat_cnt_q, beat_cnt_d;

    logic [IDW-1:0]        sel;
    logic                  sel_any;
    logic                  in_burst;
    logic                  gnt_valid;
    logic                  xfer;
    logic                  last_beat;
    logic [NUM_REQ-1:0]    ready;
    logic [DATA_WIDTH-1:0] w_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (sel),
        .any_o        (sel_any)
    );

    assign in_burst  = (state_q == BURST);
    assign xfer      = in_burst & gnt_valid & ~bus.fifo_full;
    assign last_beat = (beat_cnt_q == CNTW'(MAX_BURST - 1));

    // Constant-index muxing keeps the selects free of variable part-selects.
    always_comb begin
        gnt_valid = 1'b0;
        ready     = '0;
        w_data    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (in_burst && grant_id_q == IDW'(k)) begin
                gnt_valid = bus.req_valid[k];
                ready[k]  = ~bus.fifo_full;
                w_data    = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.req_ready   = ready;
    assign bus.fifo_wr     = xfer;
    assign bus.fifo_w_data = w_data;
    assign bus.grant_valid = in_burst;
    assign bus.grant_id    = grant_id_q;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        beat_cnt_d   = beat_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    grant_id_d = sel;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // A dropped valid or the final beat ends the grant; stalls just hold.
                if (!gnt_valid || (xfer && last_beat)) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            beat_cnt_q   <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            beat_cnt_q   <= beat_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: producers modelled as word queues, expected FIFO writes queued per test.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] pmem [NR][32];
    int            phead [NR];
    int            ptail [NR];
    int            vectors = 0;
    int            miscompares = 0;

    logic          wr_s, gv_s;
    logic [1:0]    gid_s;
    logic [NR-1:0] rdy_s;

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]         = (phead[i] < ptail[i]);
            bus.req_data[i*DW +: DW] = (phead[i] < ptail[i]) ? pmem[i][phead[i]] : '0;
        end
    endtask

    task automatic load(input int id, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            pmem[id][ptail[id]] = base + DW'(k);
            ptail[id]++;
        end
    endtask

    task automatic expect_words(input int id, input int from, input int n);
        for (int k = 0; k < n; k++) sb.push_back('{id, pmem[id][from+k]});
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++) if (phead[i] < ptail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        sb.delete();
    endtask

    // One cycle: sample at negedge, retire accepted words after the edge.
    task automatic step();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc   = bus.req_valid & bus.req_ready;
        wr_s  = bus.fifo_wr;
        gv_s  = bus.grant_valid;
        gid_s = bus.grant_id;
        rdy_s = bus.req_ready;
        if (bus.fifo_wr) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got id=%0d data=%h, none expected",
                         bus.grant_id, bus.fifo_w_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'(bus.grant_id) !== e.id || bus.fifo_w_data !== e.d) begin
                    miscompares++;
                    $display("FAIL write_order: got id=%0d data=%h, want id=%0d data=%h",
                             bus.grant_id, bus.fifo_w_data, e.id, e.d);
                end
            end
        end
        if (!bus.grant_valid) begin
            vectors++;
            if ({bus.fifo_wr, bus.req_ready, bus.fifo_w_data} !== '0) begin
                miscompares++;
                $display("FAIL idle_outputs: wr=%b ready=%b data=%h, want all 0",
                         bus.fifo_wr, bus.req_ready, bus.fifo_w_data);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i]) phead[i]++;
        drive();
    endtask

    task automatic drain(input int maxc, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < maxc) begin
            step();
            n++;
            if (all_empty() && !gv_s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.fifo_full = 1'b0;
        clear_model();
        drive();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        reset_n       = 1'b0;
        bus.fifo_full = 1'b0;
        clear_model();
        for (int i = 0; i < NR; i++) load(i, 1, DW'(8'hA0 + i));
        for (int i = 0; i < NR; i++) expect_words(i, 0, 1);
        drive();
        #1;
        vectors++;
        if ({bus.grant_valid, bus.fifo_wr, bus.req_ready, bus.fifo_w_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: gv=%b wr=%b ready=%b data=%h, want all 0",
                     bus.grant_valid, bus.fifo_wr, bus.req_ready, bus.fifo_w_data);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        vectors++;
        if ({gv_s, wr_s, rdy_s} !== '0) begin
            miscompares++;
            $display("FAIL first_cycle_after_reset: gv=%b wr=%b ready=%b, want 0", gv_s, wr_s, rdy_s);
        end
        step();
        vectors++;
        if (gid_s !== 2'd0 || gv_s !== 1'b1 || wr_s !== 1'b1) begin
            miscompares++;
            $display("FAIL first_grant: id=%0d gv=%b wr=%b, want id=0 gv=1 wr=1", gid_s, gv_s, wr_s);
        end
        drain(40, ok);
        vectors++;
        if (!ok || sb.size() != 0) begin
            miscompares++;
            $display("FAIL reset_drain: done=%b left=%0d, want done=1 left=0", ok, sb.size());
        end
    endtask

    task automatic test_single_producer();
        logic [9:0] wr_tr, gv_tr;
        do_reset();
        load(2, 6, 8'h20);
        expect_words(2, 0, 6);
        drive();
        for (int c = 0; c < 10; c++) begin
            step();
            wr_tr[9-c] = wr_s;
            gv_tr[9-c] = gv_s;
        end
        vectors++;
        if (wr_tr !== 10'b0111101100 || gv_tr !== 10'b0111101110) begin
            miscompares++;
            $display("FAIL single_burst: wr=%b gv=%b, want wr=0111101100 gv=0111101110", wr_tr, gv_tr);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL single_left: %0d words, want 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        logic [25:0] wr_tr, wr_exp;
        int          gseq [5];
        bit          ok;
        do_reset();
        for (int i = 0; i < NR; i++) load(i, 8, DW'(8'h40 + i*16));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) expect_words(i, r*MB, MB);
        drive();
        for (int c = 0; c < 26; c++) begin
            step();
            wr_tr[c]  = wr_s;
            wr_exp[c] = (c > 0) && (c % 5 != 0);
            if (c % 5 == 1) gseq[c/5] = int'(gid_s);
        end
        vectors++;
        if (wr_tr !== wr_exp) begin
            miscompares++;
            $display("FAIL rr_pattern: wr=%b, want %b", wr_tr, wr_exp);
        end
        for (int b = 0; b < 5; b++) begin
            vectors++;
            if (gseq[b] !== b % NR) begin
                miscompares++;
                $display("FAIL rr_grant%0d: id=%0d, want %0d", b, gseq[b], b % NR);
            end
        end
        drain(60, ok);
        vectors++;
        if (!ok || sb.size() != 0) begin
            miscompares++;
            $display("FAIL rr_drain: done=%b left=%0d, want done=1 left=0", ok, sb.size());
        end
    endtask

    task automatic test_stall();
        int nwr;
        do_reset();
        load(1, 4, 8'h50);
        expect_words(1, 0, 4);
        drive();
        nwr = 0;
        repeat (3) begin
            step();
            nwr += int'(wr_s);
        end
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (wr_s !== 1'b0 || rdy_s !== '0 || gid_s !== 2'd1 || gv_s !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_c%0d: wr=%b ready=%b id=%0d gv=%b, want wr=0 ready=0 id=1 gv=1",
                         c, wr_s, rdy_s, gid_s, gv_s);
            end
        end
        bus.fifo_full = 1'b0;
        repeat (2) begin
            step();
            nwr += int'(wr_s);
        end
        step();
        vectors++;
        if (nwr !== 4 || gv_s !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL stall_resume: writes=%0d gv_after=%b left=%0d, want 4 0 0", nwr, gv_s, sb.size());
        end
    endtask

    task automatic test_drop();
        bit ok;
        do_reset();
        load(3, 2, 8'h30);
        expect_words(3, 0, 2);
        drive();
        step();
        load(0, 2, 8'h01);
        expect_words(0, 0, 2);
        drive();
        step();
        step();
        step();
        vectors++;
        if (gv_s !== 1'b1 || wr_s !== 1'b0 || gid_s !== 2'd3) begin
            miscompares++;
            $display("FAIL drop_cycle: gv=%b wr=%b id=%0d, want gv=1 wr=0 id=3", gv_s, wr_s, gid_s);
        end
        step();
        vectors++;
        if (gv_s !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_idle: gv=%b, want 0", gv_s);
        end
        step();
        vectors++;
        if (gid_s !== 2'd0 || gv_s !== 1'b1 || wr_s !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_next_grant: id=%0d gv=%b wr=%b, want id=0 gv=1 wr=1", gid_s, gv_s, wr_s);
        end
        drain(20, ok);
        vectors++;
        if (!ok || sb.size() != 0) begin
            miscompares++;
            $display("FAIL drop_drain: done=%b left=%0d, want done=1 left=0", ok, sb.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        do_reset();
        load(2, 4, 8'h60);
        expect_words(2, 0, 4);
        drive();
        repeat (3) step();
        load(0, 2, 8'h70);
        drive();
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.grant_valid, bus.fifo_wr, bus.req_ready, bus.fifo_w_data, bus.grant_id} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: gv=%b wr=%b ready=%b data=%h id=%0d, want all 0",
                     bus.grant_valid, bus.fifo_wr, bus.req_ready, bus.fifo_w_data, bus.grant_id);
        end
        #1 reset_n = 1'b1;
        sb.delete();
        expect_words(0, 0, 2);
        expect_words(2, 2, 2);
        step();
        vectors++;
        if (gv_s !== 1'b0 || wr_s !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_release: gv=%b wr=%b, want 0 0", gv_s, wr_s);
        end
        step();
        vectors++;
        if (gid_s !== 2'd0 || gv_s !== 1'b1 || wr_s !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_regrant: id=%0d gv=%b wr=%b, want id=0 gv=1 wr=1", gid_s, gv_s, wr_s);
        end
        drain(30, ok);
        vectors++;
        if (!ok || sb.size() != 0) begin
            miscompares++;
            $display("FAIL midreset_drain: done=%b left=%0d, want done=1 left=0", ok, sb.size());
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.fifo_full = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        test_reset();
        test_single_producer();
        test_round_robin();
        test_stall();
        test_drop();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
